// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU) holding results in HI/LO.
// One N-bit add or trial subtract per cycle on a shared carry-lookahead adder; fixed N+2 cycle latency.

module carry_look_ahead #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_c[0] = i_cin;
        for (int i = 0; i < N; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign o_sum  = w_p ^ w_c[N-1:0];
    assign o_cout = w_c[N];
endmodule

module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         hi_wr,
    input  logic         lo_wr,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_op;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_acc_hi;
    logic [N-1:0]   r_acc_lo;
    logic [N-1:0]   r_opnd;
    logic           r_sign_q;
    logic           r_sign_r;
    logic [CW-1:0]  r_count;
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic           r_done;
    logic           r_dbz;

    logic           w_is_div;
    logic           w_signed;
    logic [N-1:0]   w_a_abs;
    logic [N-1:0]   w_b_abs;
    logic [N-1:0]   w_add_a;
    logic [N-1:0]   w_add_b;
    logic [N-1:0]   w_sum;
    logic           w_cout;
    logic           w_sub_ok;
    logic [2*N-1:0] w_prod;
    logic [2*N-1:0] w_prod_fix;
    logic [N-1:0]   w_quo;
    logic [N-1:0]   w_rem;
    logic           w_dbz;

    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_a_abs  = (w_signed && r_a[N-1]) ? -r_a : r_a;
    assign w_b_abs  = (w_signed && r_b[N-1]) ? -r_b : r_b;

    // Divide shifts the partial remainder left by one before the trial subtract; its
    // dropped MSB means the shifted value already exceeds the divisor.
    assign w_add_a  = w_is_div ? {r_acc_hi[N-2:0], r_acc_lo[N-1]} : r_acc_hi;
    assign w_add_b  = w_is_div ? ~r_opnd : r_opnd;
    assign w_sub_ok = r_acc_hi[N-1] | w_cout;

    carry_look_ahead #(.N(N)) u_cla (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_is_div),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_sign_q ? -w_prod : w_prod;
    assign w_quo      = r_sign_q ? -r_acc_lo : r_acc_lo;
    assign w_rem      = r_sign_r ? -r_acc_hi : r_acc_hi;
    assign w_dbz      = w_is_div && (r_b == '0);

    // NOTE: every state element uses non-blocking assignment so all registers update
    // from the same pre-edge values; comb logic below uses blocking with defaults.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_PREP;
            S_PREP: w_next = S_RUN;
            S_RUN:  if (r_count == CW'(1)) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op <= op;
                    r_a  <= A;
                    r_b  <= B;
                end
                S_PREP: begin
                    r_acc_hi <= '0;
                    r_acc_lo <= w_is_div ? w_a_abs : w_b_abs;
                    r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
                    r_sign_q <= w_signed & (r_a[N-1] ^ r_b[N-1]);
                    r_sign_r <= w_signed & r_a[N-1];
                    r_count  <= CW'(N);
                end
                S_RUN: begin
                    r_count <= r_count - CW'(1);
                    if (w_is_div) begin
                        r_acc_hi <= w_sub_ok ? w_sum : w_add_a;
                        r_acc_lo <= {r_acc_lo[N-2:0], w_sub_ok};
                    end else if (r_acc_lo[0]) begin
                        {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[N-1:1]};
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {1'b0, r_acc_hi, r_acc_lo[N-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Architectural HI/LO: MTHI/MTLO only in IDLE, results only at FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                if (!w_is_div) begin
                    {r_hi, r_lo} <= w_prod_fix;
                end else if (w_dbz) begin
                    r_lo  <= '1;
                    r_hi  <= r_a;
                    r_dbz <= 1'b1;
                end else begin
                    r_lo <= w_quo;
                    r_hi <= w_rem;
                end
            end else if (r_state == S_IDLE) begin
                if (hi_wr) r_hi  <= wdata;
                if (lo_wr) r_lo  <= wdata;
                if (start) r_dbz <= 1'b0;
            end
        end
    end

    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case sequences,
// and random operations compared against a plain-arithmetic reference model.

module tb_mult_div_unit;
    localparam int N = 32;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: HI/LO from 64-bit products and C-style truncating division.
    function automatic void ref_model(input logic [1:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                                      output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz);
        longint sa;
        longint sb;
        longint sp;
        logic [63:0] up;
        sa   = longint'($signed(ra));
        sb   = longint'($signed(rb));
        rdbz = 1'b0;
        case (rop)
            2'b00: begin sp = sa * sb; {rhi, rlo} = sp; end
            2'b01: begin up = {32'b0, ra} * {32'b0, rb}; {rhi, rlo} = up; end
            default: begin
                if (rb == 32'h0) begin
                    rlo = 32'hFFFF_FFFF; rhi = ra; rdbz = 1'b1;
                end else if (rop == 2'b10) begin
                    sp = sa / sb; rlo = sp[31:0];
                    sp = sa % sb; rhi = sp[31:0];
                end else begin
                    rlo = ra / rb; rhi = ra % rb;
                end
            end
        endcase
    endfunction

    // Start is sampled at the posedge following the first negedge (edge 0); returns at the next negedge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt, output bit stable);
        logic [31:0] hi0;
        logic [31:0] lo0;
        bit seen;
        hi0 = hi; lo0 = lo; stable = 1'b1; seen = 1'b0; lat = 0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; seen = 1'b1; break; end
            if (busy) busy_cnt++;
            if (hi !== hi0 || lo !== lo0) stable = 1'b0;
        end
        check("done_timeout", 64'(seen), 64'd1);
    endtask

    vec_t vecs[6];

    initial begin
        int lat;
        int bcnt;
        bit stab;
        int extra;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dbz;
        logic [31:0] h0;

        reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[4] = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b0;

        // Directed table; the first entry also checks latency, busy width and done pulse width.
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_dbz_clear", i), 64'(div_by_zero), 64'd0);
            wait_done(lat, bcnt, stab);
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            check($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].exp_dbz));
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(N + 2));
            check($sformatf("v%0d_stable", i), 64'(stab), 64'd1);
            if (i == 0) begin
                check("v0_busy_cycles", 64'(bcnt), 64'(N + 2));
                check("v0_busy_at_done", 64'(busy), 64'd0);
                @(posedge clk); #1;
                check("v0_done_pulse", 64'(done), 64'd0);
            end
        end

        // Start while busy is ignored and not queued.
        start_op(2'b01, 32'd5, 32'd6);
        repeat (4) @(negedge clk);
        op = 2'b01; A = 32'd100; B = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt, stab);
        check("ign_lo", 64'(lo), 64'd30);
        check("ign_hi", 64'(hi), 64'd0);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("ign_extra_done", 64'(extra), 64'd0);
        check("ign_idle", 64'(busy), 64'd0);

        // MTHI while busy is ignored, then honoured in IDLE.
        start_op(2'b11, 32'd7, 32'd2);
        h0 = hi;
        repeat (2) @(negedge clk);
        hi_wr = 1'b1; wdata = 32'hCAFE_BABE;
        @(negedge clk);
        hi_wr = 1'b0;
        check("mthi_busy_hi", 64'(hi), 64'(h0));
        wait_done(lat, bcnt, stab);
        check("mthi_busy_res_hi", 64'(hi), 64'd1);
        check("mthi_busy_res_lo", 64'(lo), 64'd3);
        @(negedge clk);
        hi_wr = 1'b1;
        @(posedge clk); #1;
        check("mthi_idle_hi", 64'(hi), 64'hCAFE_BABE);
        @(negedge clk);
        hi_wr = 1'b0;

        // MTLO together with start: write lands, then result overwrites it.
        @(negedge clk);
        op = 2'b01; A = 32'd3; B = 32'd4; start = 1'b1; lo_wr = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        check("mtlo_start_lo", 64'(lo), 64'h1234_5678);
        @(negedge clk);
        start = 1'b0; lo_wr = 1'b0;
        wait_done(lat, bcnt, stab);
        check("mtlo_start_res_lo", 64'(lo), 64'd12);
        check("mtlo_start_res_hi", 64'(hi), 64'd0);

        // Asynchronous reset mid-operation, then a clean operation.
        start_op(2'b01, 32'hFFFF_FFFF, 32'd2);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        start_op(2'b00, 32'hFFFF_FFFE, 32'd3);
        wait_done(lat, bcnt, stab);
        check("rst_after_hi", 64'(hi), 64'hFFFF_FFFF);
        check("rst_after_lo", 64'(lo), 64'hFFFF_FFFA);
        check("rst_after_lat", 64'(lat), 64'(N + 2));

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  r_op;
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'h0;
                1:       r_b = 32'($urandom_range(1, 20));
                2:       r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            ref_model(r_op, r_a, r_b, e_hi, e_lo, e_dbz);
            start_op(r_op, r_a, r_b);
            wait_done(lat, bcnt, stab);
            check($sformatf("rnd%0d_op%0d_hi", i, r_op), 64'(hi), 64'(e_hi));
            check($sformatf("rnd%0d_op%0d_lo", i, r_op), 64'(lo), 64'(e_lo));
            check($sformatf("rnd%0d_dbz", i), 64'(div_by_zero), 64'(e_dbz));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(N + 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath. It implements MULT, MULTU, DIV and DIVU and holds the results in the architectural HI/LO registers.
- Sits downstream of the carry_look_ahead adder: each iteration consumes one N-bit add/subtract from an internal carry_look_ahead #(N) instance.
- Radix-2, one bit per cycle, fixed latency for every operation.

Parameters:
- N, 32, operand width; HI and LO are N bits each.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  in  N  multiplicand / dividend (rs).
- B  in  N  multiplier / divisor (rt).
- hi_wr  in  1  MTHI: load hi from wdata.
- lo_wr  in  1  MTLO: load lo from wdata.
- wdata  in  N  data for hi_wr / lo_wr.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when hi/lo receive a result.
- hi  out  N  HI register: product upper half, or remainder.
- lo  out  N  LO register: product lower half, or quotient.
- div_by_zero  out  1  set with done when a DIV/DIVU had B==0; cleared at the next accepted start.

Behaviour:
- Clock and reset: one clock (clk), asynchronous active-high reset (reset).
- Reset value: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0.
- Reset is effective immediately, including mid-operation; the partial result is discarded.
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE: on start=1, latch op, A and B, clear div_by_zero, go to PREP.
- PREP: for signed ops, take absolute values of the operands; record the result sign (A[N-1]^B[N-1]) and the remainder sign (A[N-1]); load the iteration counter with N; go to RUN.
- RUN, multiply: shift-add on a 2N-bit accumulator.
- RUN, divide: restoring shift-subtract. The subtract is done on the adder as A + ~B with C_in=1; C_out=1 means the trial subtract did not go negative.
- RUN: decrement the counter each cycle; after N iterations go to FIX.
- FIX: apply two's-complement correction to the product, quotient and remainder per the recorded signs; write hi/lo; pulse done=1; return to IDLE.
- Latency: with start sampled at edge 0, hi/lo update and done=1 occur at edge N+2 (edge 34 for N=32).
- busy=1 from edge 0 through edge N+2 exclusive; equivalently, busy = state != IDLE.
- start while busy is ignored and is not queued.
- Divide by zero: the unit still takes the full latency. At FIX it forces lo=all ones and hi=latched A (unsigned dividend, uncorrected), and sets div_by_zero=1.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: result is lo=0x80000000, hi=0 (natural truncation). No flag is raised.
- hi_wr / lo_wr are honoured only in IDLE and are ignored while busy.
- If hi_wr/lo_wr and start arrive in the same IDLE cycle, both take effect. The write lands now and is overwritten by the result at edge N+2.
- done is low in every cycle except the one following the FIX edge.
- hi and lo are stable (hold their previous values) for the whole operation until FIX.

Test Plan:
- Reset then MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF → done at edge 34, hi=0xFFFFFFFE, lo=0x00000001, busy high for exactly 34 cycles.
- MULT with A=0xFFFFFFFE (-2), B=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 → lo=3, hi=1.
- DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0. DIVU A=0x12345678, B=0 → lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1.
- start pulsed at cycle 5 of a running op → ignored, only one done seen. hi_wr with wdata=0xCAFEBABE while busy → hi unchanged. The same hi_wr in IDLE → hi=0xCAFEBABE next edge.
- reset asserted at cycle 10 of a MULTU → busy=0, hi=lo=0 immediately. A new start is then accepted normally and completes with the correct result.
